// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with write-back bypass, pending scoreboard and RAW stall request
module reg_file_sb #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              wb_rd_enable,
    input  logic [ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_rd_data,
    input  logic              rs1_read_enable,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic              rs2_read_enable,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              issue_valid,
    input  logic              issue_rd_enable,
    input  logic [ADDR_W-1:0] issue_rd_addr,
    input  logic              flush,
    output logic              reg_stall_req
);
    logic [DATA_W-1:0]  regs_q [REG_NUM];
    logic [DATA_W-1:0]  regs_d [REG_NUM];
    logic [REG_NUM-1:0] pend_q, pend_d;
    logic               hit1, hit2, haz1, haz2;

    always_comb begin
        regs_d = regs_q;
        if (rdy && wb_rd_enable && wb_rd_addr != '0)
            regs_d[wb_rd_addr] = wb_rd_data;
        regs_d[0] = '0;
    end

    // clear is applied before set so a same-cycle issue to the same rd wins
    always_comb begin
        pend_d = pend_q;
        if (rdy) begin
            if (flush) begin
                pend_d = '0;
            end else begin
                if (wb_rd_enable)
                    pend_d[wb_rd_addr] = 1'b0;
                if (issue_valid && issue_rd_enable && issue_rd_addr != '0)
                    pend_d[issue_rd_addr] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++)
                regs_q[i] <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign hit1 = wb_rd_enable && wb_rd_addr == rs1_addr;
    assign hit2 = wb_rd_enable && wb_rd_addr == rs2_addr;

    assign rs1_data = (!rst || !rs1_read_enable || rs1_addr == '0) ? '0 :
                      hit1 ? wb_rd_data : regs_q[rs1_addr];
    assign rs2_data = (!rst || !rs2_read_enable || rs2_addr == '0) ? '0 :
                      hit2 ? wb_rd_data : regs_q[rs2_addr];

    assign haz1 = rs1_read_enable && rs1_addr != '0 && pend_q[rs1_addr] && !hit1;
    assign haz2 = rs2_read_enable && rs2_addr != '0 && pend_q[rs2_addr] && !hit2;
    assign reg_stall_req = rst && (haz1 || haz2);
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        wb_rd_enable;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        rs1_read_enable, rs2_read_enable;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid, issue_rd_enable;
    logic [4:0]  issue_rd_addr;
    logic        flush, reg_stall_req;

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .wb_rd_enable(wb_rd_enable), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .rs1_read_enable(rs1_read_enable), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_read_enable(rs2_read_enable), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_rd_enable(issue_rd_enable),
        .issue_rd_addr(issue_rd_addr), .flush(flush), .reg_stall_req(reg_stall_req)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1;
        wb_rd_enable = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
        rs1_read_enable = 1'b0; rs1_addr = '0;
        rs2_read_enable = 1'b0; rs2_addr = '0;
        issue_valid = 1'b0; issue_rd_enable = 1'b0; issue_rd_addr = '0;
        flush = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_rd_enable = 1'b1; wb_rd_addr = a; wb_rd_data = d;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_valid = 1'b1; issue_rd_enable = 1'b1; issue_rd_addr = a;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rs1_read_enable = 1'b1; rs1_addr = a1;
        rs2_read_enable = 1'b1; rs2_addr = a2;
    endtask

    // Expected values are queued as the stimulus is applied, then popped once outputs settle.
    task automatic step(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                        input logic es, input bit advance = 1'b1);
        exp_t x;
        sb.push_back('{tag, e1, e2, es});
        #3;
        x = sb.pop_front();
        cmp({x.tag, ".rs1"}, rs1_data, x.d1);
        cmp({x.tag, ".rs2"}, rs2_data, x.d2);
        cmp({x.tag, ".stall"}, {31'd0, reg_stall_req}, {31'd0, x.st});
        if (advance) begin
            @(posedge clk);
            #1;
            idle();
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rd(5'd5, 5'd7);
        wb(5'd5, 32'h77);
        step("reset_outputs", 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        idle();
        @(posedge clk); #1;

        rd(5'd5, 5'd0);
        step("t1_x5_init", 32'h0, 32'h0, 1'b0);
        wb(5'd5, 32'hDEADBEEF);
        step("t1_wb_no_read", 32'h0, 32'h0, 1'b0);
        rd(5'd5, 5'd5);
        step("t1_x5_read", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

        wb(5'd0, 32'h12345678); issue(5'd0); rd(5'd0, 5'd5);
        step("t2_x0_bypass", 32'h0, 32'hDEADBEEF, 1'b0);
        rd(5'd0, 5'd0);
        step("t2_x0_after", 32'h0, 32'h0, 1'b0);

        issue(5'd7); rd(5'd5, 5'd7);
        step("t3_issue7", 32'hDEADBEEF, 32'h0, 1'b0);
        rd(5'd7, 5'd0);
        step("t3_raw_stall", 32'h0, 32'h0, 1'b1);
        rd(5'd7, 5'd0); wb(5'd7, 32'h55);
        step("t3_wb_resolves", 32'h55, 32'h0, 1'b0);
        rd(5'd7, 5'd7);
        step("t3_after_wb", 32'h55, 32'h55, 1'b0);

        issue(5'd9);
        step("t4_issue9", 32'h0, 32'h0, 1'b0);
        wb(5'd9, 32'h99); issue(5'd9); rd(5'd9, 5'd0);
        step("t4_set_clr_same", 32'h99, 32'h0, 1'b0);
        rd(5'd9, 5'd0);
        step("t4_set_wins", 32'h99, 32'h0, 1'b1);
        wb(5'd9, 32'h9A); rd(5'd0, 5'd9);
        step("t4_clear9", 32'h0, 32'h9A, 1'b0);
        rd(5'd0, 5'd9);
        step("t4_after_clear", 32'h0, 32'h9A, 1'b0);

        issue(5'd3);
        step("t5_issue3", 32'h0, 32'h0, 1'b0);
        issue(5'd4); rd(5'd3, 5'd0);
        step("t5_issue4", 32'h0, 32'h0, 1'b1);
        flush = 1'b1; issue(5'd6); rd(5'd0, 5'd4);
        step("t5_flush_cycle", 32'h0, 32'h0, 1'b1);
        rd(5'd3, 5'd4);
        step("t5_x3x4_clear", 32'h0, 32'h0, 1'b0);
        rd(5'd6, 5'd6);
        step("t5_x6_clear", 32'h0, 32'h0, 1'b0);

        rdy = 1'b0; wb(5'd2, 32'hA); issue(5'd2); rd(5'd2, 5'd0);
        step("t6_frozen_bypass", 32'hA, 32'h0, 1'b0);
        rd(5'd2, 5'd2);
        step("t6_x2_unchanged", 32'h0, 32'h0, 1'b0);

        issue(5'd10);
        step("t7_issue10", 32'h0, 32'h0, 1'b0);
        rdy = 1'b0; wb(5'd10, 32'hB0);
        step("t7_frozen_clear", 32'h0, 32'h0, 1'b0);
        rd(5'd10, 5'd0);
        step("t7_still_pending", 32'h0, 32'h0, 1'b1);
        wb(5'd10, 32'hB1);
        step("t7_clear10", 32'h0, 32'h0, 1'b0);

        issue(5'd8);
        step("t8_issue8", 32'h0, 32'h0, 1'b0);
        rd(5'd5, 5'd8);
        step("t8_pre_reset", 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        step("t8_in_reset", 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        idle();
        @(posedge clk); #1;
        rd(5'd5, 5'd8);
        step("t8_post_reset", 32'h0, 32'h0, 1'b0);
        rd(5'd7, 5'd10);
        step("t8_regs_cleared", 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
